// File: rtl/truth_table_sequencer_if.sv
// Host and function-under-test signals of the truth table sequencer.
// TTSEQ_ABORT_EN adds the abort request line.
interface truth_table_sequencer_if #(
    parameter int N_IN = 4
);
    localparam int T = 1 << N_IN;

    logic            start;
    logic [T-1:0]    exp_mask;
    logic            y;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic [T-1:0]    table_o;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_err;
    logic            pass;
`ifdef TTSEQ_ABORT_EN
    logic            abort;

    modport master (
        output start, exp_mask, y, abort,
        input  vec, busy, done, table_o, err_cnt, first_err, pass
    );
    modport slave (
        input  start, exp_mask, y, abort,
        output vec, busy, done, table_o, err_cnt, first_err, pass
    );
`else
    modport master (
        output start, exp_mask, y,
        input  vec, busy, done, table_o, err_cnt, first_err, pass
    );
    modport slave (
        input  start, exp_mask, y,
        output vec, busy, done, table_o, err_cnt, first_err, pass
    );
`endif
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps all input vectors through a combinational block and checks Y.
// Optional TTSEQ_ABORT_EN lets the host cancel a sweep in progress.
module truth_table_sequencer #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    truth_table_sequencer_if.slave bus
);
    localparam int              T        = 1 << N_IN;
    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
    localparam logic [N_IN-1:0] LAST     = N_IN'(T - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      settle_cnt;
    logic [N_IN-1:0] vec_q;
    logic [N_IN-1:0] first_err_q;
    logic [T-1:0]    expect_q;
    logic [T-1:0]    table_q;
    logic [N_IN:0]   err_cnt_q;
    logic            pass_q;
    logic            accept;
    logic            sample;
    logic            abort_req;
    logic            mismatch;

`ifdef TTSEQ_ABORT_EN
    assign abort_req = (state_q == DRIVE) && bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    assign mismatch = bus.y != expect_q[vec_q];

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Abort wins over a final sample landing on the same edge.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        sample  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (abort_req) begin
                    state_d = IDLE;
                end else if (settle_cnt == SETTLE_C) begin
                    sample = 1'b1;
                    if (vec_q == LAST) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q       <= '0;
            settle_cnt  <= '0;
            expect_q    <= '0;
            table_q     <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else if (accept) begin
            vec_q       <= '0;
            settle_cnt  <= '0;
            expect_q    <= bus.exp_mask;
            table_q     <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else if (state_q == DRIVE && !abort_req) begin
            if (sample) begin
                table_q[vec_q] <= bus.y;
                if (mismatch) begin
                    err_cnt_q <= err_cnt_q + (N_IN + 1)'(1);
                    if (err_cnt_q == '0) first_err_q <= vec_q;
                end
                // The last vector stays on the bus after the sweep.
                if (vec_q != LAST) begin
                    vec_q      <= vec_q + N_IN'(1);
                    settle_cnt <= '0;
                end
            end else begin
                settle_cnt <= settle_cnt + 4'd1;
            end
        end else if (state_q == DONE) begin
            pass_q <= (err_cnt_q == '0);
        end
    end

    assign bus.vec       = vec_q;
    assign bus.busy      = (state_q == DRIVE);
    assign bus.done      = (state_q == DONE);
    assign bus.table_o   = table_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.first_err = first_err_q;
    assign bus.pass      = pass_q;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: 3-input/SETTLE=1 and 4-input/SETTLE=0
// instances; abort scenario runs when TTSEQ_ABORT_EN is defined.
module tb_truth_table_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    truth_table_sequencer_if #(.N_IN(3)) b3();
    truth_table_sequencer_if #(.N_IN(4)) b4();

    truth_table_sequencer #(.N_IN(3), .SETTLE(1)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(b3)
    );
    truth_table_sequencer #(.N_IN(4), .SETTLE(0)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(b4)
    );

    // Y = A&C | ~A&~B&C, vector index = {A,B,C}
    function automatic logic f3(input logic [2:0] v);
        return (v[2] & v[0]) | (~v[2] & ~v[1] & v[0]);
    endfunction

    assign b3.y = f3(b3.vec);
    assign b4.y = 1'b0;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] tbl;
        logic [3:0] err;
        logic [2:0] first;
        logic       pass;
    } rec_t;

    rec_t vecs[7];
    rec_t sb[$];
    rec_t r;
    int   errors = 0;
    int   checks = 0;
    int   lat;
    int   nd;
    int   cyc;
    int   bad;
    logic [7:0] model_tbl;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep3(input logic [7:0] mask, input int ign_at,
                          output int lat_o, output int nd_o);
        int c;
        b3.exp_mask = mask;
        b3.start    = 1'b1;
        step();
        b3.start = 1'b0;
        chk("busy_after_start", 32'(b3.busy), 1);
        c    = 1;
        nd_o = 0;
        while (!b3.done && c < 100) begin
            b3.start = (c == ign_at);
            step();
            c++;
        end
        b3.start = 1'b0;
        if (b3.done) begin
            lat_o = c;
            nd_o  = 1;
        end else begin
            lat_o = -1;
        end
        repeat (4) begin
            step();
            if (b3.done) nd_o++;
        end
    endtask

    task automatic sweep4(input logic [15:0] mask, output int lat_o,
                          output int bad_o);
        int c;
        b4.exp_mask = mask;
        b4.start    = 1'b1;
        step();
        b4.start = 1'b0;
        c     = 1;
        bad_o = 0;
        while (!b4.done && c < 100) begin
            if (b4.vec != 4'(c - 1) || !b4.busy) bad_o++;
            step();
            c++;
        end
        lat_o = b4.done ? c : -1;
        step();
    endtask

    initial begin
        model_tbl = '0;
        for (int i = 0; i < 8; i++) model_tbl[i] = f3(3'(i));
        vecs[0] = '{8'hA2, 8'hA2, 4'd0, 3'd0, 1'b1};
        vecs[1] = '{8'hA0, 8'hA2, 4'd1, 3'd1, 1'b0};
        vecs[2] = '{8'h00, 8'hA2, 4'd3, 3'd1, 1'b0};
        vecs[3] = '{8'hFF, 8'hA2, 4'd5, 3'd0, 1'b0};
        vecs[4] = '{8'h5D, 8'hA2, 4'd8, 3'd0, 1'b0};
        vecs[5] = '{8'hA3, 8'hA2, 4'd1, 3'd0, 1'b0};
        vecs[6] = '{8'h22, 8'hA2, 4'd1, 3'd7, 1'b0};

        rst_n       = 1'b0;
        b3.start    = 1'b0;
        b3.exp_mask = '0;
        b4.start    = 1'b0;
        b4.exp_mask = '0;
`ifdef TTSEQ_ABORT_EN
        b3.abort = 1'b0;
        b4.abort = 1'b0;
`endif
        repeat (3) step();
        rst_n = 1'b1;

        chk("model_tbl", 32'(model_tbl), 32'hA2);
        chk("rst_vec", 32'(b3.vec), 0);
        chk("rst_busy", 32'(b3.busy), 0);
        chk("rst_done", 32'(b3.done), 0);
        chk("rst_table", 32'(b3.table_o), 0);
        chk("rst_err", 32'(b3.err_cnt), 0);
        chk("rst_first", 32'(b3.first_err), 0);
        chk("rst_pass", 32'(b3.pass), 0);
        chk("rst4_table", 32'(b4.table_o), 0);

        foreach (vecs[i]) begin
            sb.push_back(vecs[i]);
            sweep3(vecs[i].mask, 0, lat, nd);
            chk("t3_latency", lat, 17);
            chk("t3_ndone", nd, 1);
            if (nd != 0) begin
                r = sb.pop_front();
                chk("t3_table", 32'(b3.table_o), 32'(r.tbl));
                chk("t3_err", 32'(b3.err_cnt), 32'(r.err));
                chk("t3_pass", 32'(b3.pass), 32'(r.pass));
                if (r.err != 0)
                    chk("t3_first", 32'(b3.first_err), 32'(r.first));
                chk("t3_idle_busy", 32'(b3.busy), 0);
            end
        end

        sweep3(8'hA2, 5, lat, nd);
        chk("ign_latency", lat, 17);
        chk("ign_ndone", nd, 1);
        chk("ign_table", 32'(b3.table_o), 32'hA2);

        b3.exp_mask = 8'hA2;
        b3.start    = 1'b1;
        cyc = 0;
        while (!b3.done && cyc < 100) begin
            step();
            cyc++;
        end
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!b3.done && cyc < 100);
        b3.start = 1'b0;
        chk("b2b_gap", cyc, 18);
        nd = 0;
        repeat (4) begin
            step();
            if (b3.done || b3.busy) nd++;
        end
        chk("b2b_stops", nd, 0);

        sweep4(16'hFFFF, lat, bad);
        chk("w4_latency", lat, 17);
        chk("w4_vec_steps", bad, 0);
        chk("w4_err", 32'(b4.err_cnt), 16);
        chk("w4_first", 32'(b4.first_err), 0);
        chk("w4_pass", 32'(b4.pass), 0);
        chk("w4_table", 32'(b4.table_o), 0);
        chk("w4_vec_hold", 32'(b4.vec), 15);
        sweep4(16'h8000, lat, bad);
        chk("w4b_err", 32'(b4.err_cnt), 1);
        chk("w4b_first", 32'(b4.first_err), 15);
        sweep4(16'h0000, lat, bad);
        chk("w4c_pass", 32'(b4.pass), 1);

        b3.exp_mask = 8'hA2;
        b3.start    = 1'b1;
        step();
        b3.start = 1'b0;
        cyc = 1;
        while (cyc < 8) begin
            step();
            cyc++;
        end
        chk("rm_pre_table", 32'(b3.table_o), 32'h02);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rm_busy", 32'(b3.busy), 0);
        chk("rm_vec", 32'(b3.vec), 0);
        chk("rm_table", 32'(b3.table_o), 0);
        chk("rm_err", 32'(b3.err_cnt), 0);
        chk("rm_done", 32'(b3.done), 0);
        nd = 0;
        repeat (40) begin
            step();
            if (b3.done) nd++;
        end
        chk("rm_no_done", nd, 0);

`ifdef TTSEQ_ABORT_EN
        sweep3(8'hA2, 0, lat, nd);
        chk("ab_pre_pass", 32'(b3.pass), 1);
        b3.exp_mask = 8'hA2;
        b3.start    = 1'b1;
        step();
        b3.start = 1'b0;
        cyc = 1;
        while (cyc < 7) begin
            step();
            cyc++;
        end
        b3.abort = 1'b1;
        step();
        b3.abort = 1'b0;
        chk("ab_busy", 32'(b3.busy), 0);
        chk("ab_done", 32'(b3.done), 0);
        chk("ab_table", 32'(b3.table_o[2:0]), 32'(model_tbl[2:0]));
        chk("ab_pass", 32'(b3.pass), 0);
        nd = 0;
        repeat (20) begin
            step();
            if (b3.done || b3.busy) nd++;
        end
        chk("ab_no_done", nd, 0);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
